// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [15:0] RESET_PC     = 16'h0000;
  localparam logic [15:0] BUBBLE_INSTR = 16'h0000;
  localparam logic [15:0] BUBBLE_PC    = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE   = 4'hF;

  // Fetch FSM encoding; the halted output mirrors this state directly.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // Opcode lives in the top nibble of the instruction word.
  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == HLT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: reset > bubble > hold > load.
// A bubble is marked by pc_out == BUBBLE_PC (PC+1 of a real fetch is never 0,
// except for the word at 16'hFFFF, which is thereby squashed on purpose).
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out
);

  logic [15:0] instr_d, instr_q;
  logic [15:0] pc_d, pc_q;

  // Next-state selection for the held instruction and its PC+1.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (bubble) begin
      instr_d = BUBBLE_INSTR;
      pc_d    = BUBBLE_PC;
    end else if (!hold) begin
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  // Register update with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= BUBBLE_INSTR;
      pc_q    <= BUBBLE_PC;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, RUN/HALTED FSM and the IF/ID register.
// Per-cycle priority: rst > redirect > hlt > flush > stall > normal fetch.
// Once HALTED, only rst leaves the state; all other controls are ignored.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  input  logic [15:0] im_instr,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        halted
);

  fetch_state_e state_d, state_q;
  logic [15:0]  pc_d, pc_q;
  logic         halted_d, halted_q;
  logic [15:0]  pc_plus1;
  logic         ifid_bubble;
  logic         ifid_hold;

  // Wraps modulo 2^16 by width.
  assign pc_plus1 = pc_q + 16'd1;

  // Control decode: next PC, next FSM state and IF/ID hold/bubble requests.
  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    halted_d    = halted_q;
    ifid_bubble = 1'b0;
    ifid_hold   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
        end else if (hlt) begin
          state_d     = ST_HALTED;
          halted_d    = 1'b1;
          ifid_bubble = 1'b1;
        end else if (flush) begin
          ifid_bubble = 1'b1;
        end else if (stall) begin
          ifid_hold   = 1'b1;
        end else begin
          pc_d        = pc_plus1;
        end
      end
      ST_HALTED: begin
        ifid_bubble = 1'b1;
      end
      default: begin
        state_d     = ST_RUN;
        halted_d    = 1'b0;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  // PC and FSM registers with synchronous reset into RUN at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (ifid_hold),
    .bubble    (ifid_bubble),
    .instr_in  (im_instr),
    .pc_in     (pc_plus1),
    .instr_out (instr_out),
    .pc_out    (pc_out)
  );

  assign im_addr  = pc_q;
  assign im_rd_en = (state_q == ST_RUN) && !rst;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory model: mem[a] = a + 16'h1000.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        halted;

  int n_cmp;
  int n_err;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt         (hlt),
    .im_addr     (im_addr),
    .im_rd_en    (im_rd_en),
    .im_instr    (im_instr),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory
  assign im_instr = im_addr + 16'h1000;

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks im_addr, pc_out, instr_out together.
  task automatic check_if(input string tag, input logic [15:0] a,
                          input logic [15:0] p, input logic [15:0] i);
    check({tag, ".im_addr"},   im_addr,   a);
    check({tag, ".pc_out"},    pc_out,    p);
    check({tag, ".instr_out"}, instr_out, i);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 16'h0000; hlt = 1'b0;

    // Reset state
    tick(); tick();
    check_if("reset", 16'h0000, 16'h0000, 16'h0000);
    check("reset.halted",   {15'd0, halted},   16'd0);
    check("reset.im_rd_en", {15'd0, im_rd_en}, 16'd0);

    // Sequential fetch after release
    rst = 1'b0;
    #1;
    check("rel.im_rd_en", {15'd0, im_rd_en}, 16'd1);
    tick();
    check_if("seq1", 16'h0001, 16'h0001, 16'h1000);
    tick();
    check_if("seq2", 16'h0002, 16'h0002, 16'h1001);
    tick(); tick(); tick();
    check_if("seq5", 16'h0005, 16'h0005, 16'h1004);

    // Stall three cycles at PC=5
    stall = 1'b1;
    tick();
    check_if("stall1", 16'h0005, 16'h0005, 16'h1004);
    tick();
    check_if("stall2", 16'h0005, 16'h0005, 16'h1004);
    tick();
    check_if("stall3", 16'h0005, 16'h0005, 16'h1004);
    check("stall.im_rd_en", {15'd0, im_rd_en}, 16'd1);
    stall = 1'b0;
    tick();
    check_if("resume", 16'h0006, 16'h0006, 16'h1005);

    // Redirect overrides stall
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    tick();
    check_if("redir", 16'h0040, 16'h0000, 16'h0000);
    redirect = 1'b0; stall = 1'b0;
    tick();
    check_if("redir_next", 16'h0041, 16'h0041, 16'h1040);

    // Flush: bubble, PC holds
    flush = 1'b1;
    tick();
    check_if("flush", 16'h0041, 16'h0000, 16'h0000);
    flush = 1'b0;
    tick();
    check_if("flush_next", 16'h0042, 16'h0042, 16'h1041);

    // Halt at PC=8
    redirect = 1'b1; redirect_pc = 16'h0008;
    tick();
    check_if("to8", 16'h0008, 16'h0000, 16'h0000);
    redirect = 1'b0; hlt = 1'b1; flush = 1'b1;
    tick();
    check_if("halt", 16'h0008, 16'h0000, 16'h0000);
    check("halt.halted",   {15'd0, halted},   16'd1);
    check("halt.im_rd_en", {15'd0, im_rd_en}, 16'd0);
    hlt = 1'b0; flush = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    check_if("halt_redir", 16'h0008, 16'h0000, 16'h0000);
    check("halt_redir.halted", {15'd0, halted}, 16'd1);
    redirect = 1'b0; stall = 1'b1;
    tick();
    check_if("halt_stall", 16'h0008, 16'h0000, 16'h0000);
    stall = 1'b0; rst = 1'b1;
    tick();
    check_if("halt_rst", 16'h0000, 16'h0000, 16'h0000);
    check("halt_rst.halted", {15'd0, halted}, 16'd0);
    rst = 1'b0;
    tick();
    check_if("after_halt", 16'h0001, 16'h0001, 16'h1000);
    check("after_halt.im_rd_en", {15'd0, im_rd_en}, 16'd1);

    // Wrap at 16'hFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    check_if("wrap_redir", 16'hFFFF, 16'h0000, 16'h0000);
    redirect = 1'b0;
    tick();
    check_if("wrap_fetch", 16'h0000, 16'h0000, 16'h0FFF);
    tick();
    check_if("wrap_next", 16'h0001, 16'h0001, 16'h1000);

    // Reset dominates stall, hlt and redirect
    tick(); tick();
    stall = 1'b1; hlt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0077; rst = 1'b1;
    tick();
    check_if("rst_dom", 16'h0000, 16'h0000, 16'h0000);
    check("rst_dom.halted", {15'd0, halted}, 16'd0);
    stall = 1'b0; hlt = 1'b0; redirect = 1'b0; rst = 1'b0;
    tick();
    check_if("rst_dom_next", 16'h0001, 16'h0001, 16'h1000);

    // Redirect beats hlt in the same cycle
    redirect = 1'b1; redirect_pc = 16'h0200; hlt = 1'b1;
    tick();
    check_if("redir_hlt", 16'h0200, 16'h0000, 16'h0000);
    check("redir_hlt.halted", {15'd0, halted}, 16'd0);
    redirect = 1'b0; hlt = 1'b0;
    tick();
    check_if("redir_hlt_next", 16'h0201, 16'h0201, 16'h1200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 stall  input  1  hazard hold; freezes PC and IF/ID register.
REQ-004 flush  input  1  squash the IF/ID register contents.
REQ-005 redirect  input  1  taken branch, jal or jr; load redirect_pc.
REQ-006 redirect_pc  input  16  redirect target word address.
REQ-007 hlt  input  1  halt instruction decoded in ID this cycle.
REQ-008 im_addr  output  16  instruction memory word address; equals current PC.
REQ-009 im_rd_en  output  1  instruction memory read enable.
REQ-010 im_instr  input  16  instruction word, combinational read of im_addr in the same cycle.
REQ-011 instr_out  output  16  IF/ID instruction register to the decoder.
REQ-012 pc_out  output  16  IF/ID PC+1 of the held instruction; 16'h0000 marks a bubble.
REQ-013 halted  output  1  high while the fetch FSM is in HALTED.

Function
REQ-014 Per-cycle priority SHALL be: rst > redirect > hlt > flush > stall > normal fetch.
REQ-015 Normal fetch: PC <= PC+1; instr_out <= im_instr; pc_out <= PC+1; latency fetch-to-ID is one cycle.
REQ-016 Redirect: PC <= redirect_pc; IF/ID <= bubble (instr_out 16'h0000, pc_out 16'h0000); redirect overrides stall, flush and hlt in the same cycle.
REQ-017 Flush without redirect: IF/ID <= bubble; PC holds.
REQ-018 Stall (no redirect, flush or hlt): PC, instr_out and pc_out hold; im_rd_en stays 1.
REQ-019 FSM states: RUN and HALTED; reset enters RUN.
REQ-020 RUN -> HALTED when hlt=1 and redirect=0; the transition cycle loads IF/ID with a bubble and holds PC.
REQ-021 HALTED: PC frozen, IF/ID bubble, im_rd_en=0, halted=1; stall, flush, redirect and hlt are ignored; only rst exits.
REQ-022 PC arithmetic is 16-bit modulo; 16'hFFFF+1 = 16'h0000.
REQ-023 The instruction at 16'hFFFF yields pc_out=16'h0000 and is thereby squashed; this boundary is accepted, not trapped.
REQ-024 im_rd_en = 1 in RUN, 0 in HALTED and during reset.

Reset
REQ-025 When rst=1 at a clock edge: PC <= 16'h0000, instr_out <= 16'h0000, pc_out <= 16'h0000, state <= RUN, halted <= 0.
REQ-026 Reset SHALL dominate every other input, including mid-stall, mid-redirect and HALTED.
REQ-027 The first cycle after reset release fetches address 16'h0000 and presents it with pc_out=16'h0001.

Structure
REQ-028 A shared package SHALL hold RESET_PC (16'h0000), BUBBLE_INSTR (16'h0000), BUBBLE_PC (16'h0000), the HLT opcode (4'hF) and the FSM state encoding.
REQ-029 The IF/ID register SHALL be a sub-module, if_id_reg, with hold and bubble inputs; the PC and FSM SHALL stay in fetch_unit.

Verification
REQ-030 Reset release, IM holds sequential words, no control inputs: pc_out = 1,2,3...; instr_out = mem[0],mem[1]...; im_addr leads pc_out-1 by one cycle.
REQ-031 stall=1 for 3 cycles at PC=5: im_addr stays 5; pc_out stays 5; instr_out stays mem[4]; fetch resumes at 5 afterwards.
REQ-032 redirect=1, redirect_pc=16'h0040, stall=1 in the same cycle: next cycle im_addr=0x0040 and pc_out=0; the following cycle pc_out=0x0041.
REQ-033 hlt=1 at PC=8: halted=1 from the next cycle, im_rd_en=0, pc_out=0, im_addr held at 8; a later redirect is ignored; rst returns to PC=0.
REQ-034 redirect_pc=16'hFFFF: pc_out=0 for the fetched word; next im_addr=16'h0000 (wrap).
REQ-035 rst asserted during stall with hlt=1: next cycle PC=0, RUN, all outputs at reset values.
